rf_wport_arbiter: RTL
=====================

Name: rf_wport_arbiter

Overview:
- Shares the register file's single write port between two writers.
- The pipeline writeback stage always has priority and is never stalled by this block.
- The long-latency unit (divider/load return) uses a valid/ready handshake and is queued in a DEPTH-entry FIFO. Queued entries drain into idle write-port cycles.
- Also provides read-hazard flags for queued writes and forces a pipeline bubble when a queued write starves.

Parameters:
- DEPTH, 2, FIFO entries for long-latency writes (power of two, >=2)
- MAX_WAIT, 4, cycles the FIFO head may wait before stall_req is raised
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- wb_we  in  1  pipeline writeback write enable
- wb_waddr  in  ADDR_W  pipeline writeback address
- wb_wdata  in  DATA_W  pipeline writeback data
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  FIFO can accept
- lu_waddr  in  ADDR_W  long-latency destination
- lu_wdata  in  DATA_W  long-latency data
- rf_we  out  1  to regfile we
- rf_waddr  out  ADDR_W  to regfile waddr
- rf_wdata  out  DATA_W  to regfile wdata
- raddr1  in  ADDR_W  decode read address 1
- raddr2  in  ADDR_W  decode read address 2
- pend_hit1  out  1  raddr1 matches a live queued write
- pend_hit2  out  1  raddr2 matches a live queued write
- stall_req  out  1  request a writeback bubble
- fifo_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, rst=1): FIFO emptied, all live bits cleared, wait_cnt=0, state=IDLE. All outputs are 0: rf_we, rf_waddr, rf_wdata, lu_ready, pend_hit*, stall_req, fifo_count. Reset mid-operation discards queued writes.
- Handshake: lu_ready = !rst && count<DEPTH, from registered state only (no dependence on lu_valid). Transfer occurs when lu_valid && lu_ready at the clock edge. lu_waddr==0 transfers are accepted and dropped (not enqueued).
- Write-port mux, combinational, zero latency:
  - wb_busy = wb_we && wb_waddr!=0.
  - If wb_busy: rf_* = wb_*.
  - Else if the FIFO head exists and is live: rf_* = head, and the head pops at the edge (grant).
  - Else if the head exists but is squashed: rf_we=0 and the head pops silently.
  - Else rf_we=0, rf_waddr=0, rf_wdata=0.
- Enqueued latency: an entry can be written no earlier than the cycle after acceptance.
- Squash (WAW): when wb_busy and wb_waddr equals a live FIFO entry's address, that entry's live bit clears at the edge (the pipeline write is younger). This applies to all matching entries.
- Hazard flags: pend_hitN = raddrN!=0 && any live entry has waddr==raddrN. Combinational. Entries being enqueued this cycle are excluded.
- wait_cnt increments each cycle the head is live and not granted. It clears on grant or when the FIFO becomes empty, and saturates at MAX_WAIT.
- FSM:
  - IDLE: FIFO empty; go to WAIT on enqueue.
  - WAIT: head pending; go to STARVE when wait_cnt==MAX_WAIT-1 and no grant; go to IDLE when the last entry pops.
  - STARVE: stall_req=1 (registered, from state). Go to WAIT after the grant if entries remain, or to IDLE if the FIFO is empty. Squashed heads pop without requiring a bubble.
- Simultaneous events:
  - Enqueue and pop in the same cycle: count unchanged.
  - When full, lu_ready=0 even if a pop occurs that cycle.
- Pointers wrap modulo DEPTH.

Optional Feature:
- Macro RF_ARB_LU_BYPASS_EN.
- Defined: when the FIFO is empty, wb_busy=0, and an lu transfer with waddr!=0 occurs, the result drives rf_* in the same cycle and is not enqueued (zero latency).
- Undefined: every long-latency write passes through the FIFO (minimum 1-cycle latency).

Decomposition:
- Shared package/defines: ADDR_W, DATA_W, ZeroWord, FSM state encodings (IDLE/WAIT/STARVE), WriteEnable/RstEnable levels.
- One natural sub-module: rf_wq_fifo. It holds entries with live bits, CAM compare for squash and hazard, and head/pop logic. The top holds the mux, wait counter and FSM.

Test Plan:
- Reset during activity: enqueue 2 entries, then assert rst asynchronously mid-cycle -> fifo_count=0, rf_we=0, lu_ready=0 immediately; no write after release.
- Idle drain: lu writes r5=0x11, wb idle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x11; pend_hit1=1 for raddr1=5 only in the queued cycle.
- Starvation: queue r7=0xAB, wb_we=1 to r3 every cycle -> stall_req rises after MAX_WAIT=4 cycles; a bubble follows, then r7=0xAB is written and stall_req drops.
- WAW squash: queue r9=0x1, then wb writes r9=0x2 -> r9 is never written with 0x1; pend_hit for r9 clears after the squash edge.
- Full/back-pressure: DEPTH=2 full with wb always busy -> lu_ready=0 and lu_valid held. One pop -> lu_ready=1 the next cycle; order is preserved. lu_waddr=0 is accepted and never written.
- With RF_ARB_LU_BYPASS_EN: empty FIFO, wb idle, lu r4=0x55 -> rf_we=1 to r4 in the same cycle and fifo_count stays 0.

Source files
------------

// File: rtl/rf_wport_arbiter_pkg.sv
// rf_wport_arbiter_pkg
//   Shared definitions for the register-file write-port arbiter: default
//   address/data widths, write-enable and reset levels, FSM state encoding
//   and a helper that sizes the occupancy counter.
//   No ports (package).
package rf_wport_arbiter_pkg;

  localparam int ADDR_W_DFLT = 5;
  localparam int DATA_W_DFLT = 32;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic RST_ENABLE    = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STARVE = 2'd2
  } arb_state_e;

  // Occupancy needs one extra bit so that "full" (count == depth) is encodable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rf_wport_arbiter_if.sv
// rf_wport_arbiter_if
//   Bundles every non-clock signal of the write-port arbiter.
//   slave  : arbiter side (writeback / long-latency / decode in, regfile out)
//   master : environment side (pipeline, long-latency unit, regfile, decode)
//   Signals: wb_we/wb_waddr/wb_wdata, lu_valid/lu_ready/lu_waddr/lu_wdata,
//            rf_we/rf_waddr/rf_wdata, raddr1/raddr2, pend_hit1/pend_hit2,
//            stall_req, fifo_count.
interface rf_wport_arbiter_if
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
);
  localparam int CNT_W = cnt_width(DEPTH);

  logic              wb_we;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;

  logic              lu_valid;
  logic              lu_ready;
  logic [ADDR_W-1:0] lu_waddr;
  logic [DATA_W-1:0] lu_wdata;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic              pend_hit1;
  logic              pend_hit2;

  logic              stall_req;
  logic [CNT_W-1:0]  fifo_count;

  modport slave (
    input  wb_we, wb_waddr, wb_wdata,
    input  lu_valid, lu_waddr, lu_wdata,
    output lu_ready,
    output rf_we, rf_waddr, rf_wdata,
    input  raddr1, raddr2,
    output pend_hit1, pend_hit2,
    output stall_req, fifo_count
  );

  modport master (
    output wb_we, wb_waddr, wb_wdata,
    output lu_valid, lu_waddr, lu_wdata,
    input  lu_ready,
    input  rf_we, rf_waddr, rf_wdata,
    output raddr1, raddr2,
    input  pend_hit1, pend_hit2,
    input  stall_req, fifo_count
  );

endinterface

// File: rtl/rf_wq_fifo.sv
// rf_wq_fifo
//   Queue of pending long-latency register writes. Each entry carries a live
//   bit; a younger pipeline write to the same register clears it so the stale
//   value is dropped when it reaches the head. The address CAM serves both the
//   squash and the decode read-hazard lookups.
//   Ports:
//     clk, rst                  clock, async active-high reset
//     push_i/push_addr_i/_data_i enqueue one write
//     pop_i                     remove the head (granted or squashed)
//     squash_en_i/squash_addr_i clear live bits of matching entries
//     raddr1_i/raddr2_i         decode read addresses for hazard lookup
//     count_o                   occupancy
//     head_live_o/_addr_o/_data_o head entry
//     hit1_o/hit2_o             read address matches a live entry
module rf_wq_fifo
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [ADDR_W-1:0]       push_addr_i,
  input  logic [DATA_W-1:0]       push_data_i,
  input  logic                    pop_i,
  input  logic                    squash_en_i,
  input  logic [ADDR_W-1:0]       squash_addr_i,
  input  logic [ADDR_W-1:0]       raddr1_i,
  input  logic [ADDR_W-1:0]       raddr2_i,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    head_live_o,
  output logic [ADDR_W-1:0]       head_addr_o,
  output logic [DATA_W-1:0]       head_data_o,
  output logic                    hit1_o,
  output logic                    hit2_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  live_q, live_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  match1, match2;

  // Live bits are only ever set on occupied slots and cleared on pop, so a
  // set live bit alone identifies a pending write; no occupancy mask needed.
  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match1[i] = live_q[i] && (addr_q[i] == raddr1_i);
      match2[i] = live_q[i] && (addr_q[i] == raddr2_i);
    end
  end

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    live_d   = live_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (squash_en_i && live_q[i] && (addr_q[i] == squash_addr_i)) begin
        live_d[i] = 1'b0;
      end
    end

    if (pop_i) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PTR_W'(1);
    end

    // The write slot is never the head here: pushes only happen below full.
    if (push_i) begin
      addr_d[wr_ptr_q] = push_addr_i;
      data_d[wr_ptr_q] = push_data_i;
      live_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end

    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      live_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      live_q   <= live_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o     = count_q;
  assign head_live_o = live_q[rd_ptr_q];
  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign hit1_o      = (raddr1_i != '0) && (|match1);
  assign hit2_o      = (raddr2_i != '0) && (|match2);

endmodule

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter
//   Shares the register file's single write port between the pipeline
//   writeback stage (always wins, never stalled) and a long-latency unit whose
//   results are queued and drained into idle write-port cycles. A queued head
//   that waits MAX_WAIT cycles raises stall_req to obtain a writeback bubble.
//   Ports:
//     clk, rst  clock, async active-high reset
//     bus       rf_wport_arbiter_if.slave (writeback, long-latency handshake,
//               regfile write port, hazard lookup, stall_req, fifo_count)
//   Build option: RF_ARB_LU_BYPASS_EN lets a long-latency result go straight
//   to the write port when the queue is empty and writeback is idle.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | queue empty
//   ST_WAIT   | head pending, waiting for a free write-port cycle
//   ST_STARVE | head waited too long; stall_req asserted until it drains
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4,
  parameter int ADDR_W   = ADDR_W_DFLT,
  parameter int DATA_W   = DATA_W_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  rf_wport_arbiter_if.slave bus
);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam int WC_W  = $clog2(MAX_WAIT + 1);
  localparam logic [WC_W-1:0] WAIT_TRIP = WC_W'(MAX_WAIT - 1);
  localparam logic [WC_W-1:0] WAIT_SAT  = WC_W'(MAX_WAIT);

  logic              wb_busy;
  logic              lu_ready;
  logic              lu_take;
  logic              lu_bypass;
  logic              fifo_push;
  logic              fifo_pop;
  logic              grant;
  logic              head_valid;
  logic              head_live;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  cnt_after;
  logic              hit1, hit2;

  logic              rf_we_c;
  logic [ADDR_W-1:0] rf_waddr_c;
  logic [DATA_W-1:0] rf_wdata_c;

  arb_state_e        state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;

  // r0 is hardwired, so writes to it neither occupy the port nor queue.
  assign wb_busy    = bus.wb_we && (bus.wb_waddr != '0);
  assign lu_ready   = !rst && (fifo_count < CNT_W'(DEPTH));
  assign lu_take    = bus.lu_valid && lu_ready && (bus.lu_waddr != '0);
  assign head_valid = (fifo_count != '0);

`ifdef RF_ARB_LU_BYPASS_EN
  assign lu_bypass = lu_take && !head_valid && !wb_busy;
`else
  assign lu_bypass = 1'b0;
`endif

  assign fifo_push = lu_take && !lu_bypass;
  assign cnt_after = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

  rf_wq_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wq (
    .clk           (clk),
    .rst           (rst),
    .push_i        (fifo_push),
    .push_addr_i   (bus.lu_waddr),
    .push_data_i   (bus.lu_wdata),
    .pop_i         (fifo_pop),
    .squash_en_i   (wb_busy),
    .squash_addr_i (bus.wb_waddr),
    .raddr1_i      (bus.raddr1),
    .raddr2_i      (bus.raddr2),
    .count_o       (fifo_count),
    .head_live_o   (head_live),
    .head_addr_o   (head_addr),
    .head_data_o   (head_data),
    .hit1_o        (hit1),
    .hit2_o        (hit2)
  );

  // A squashed head is popped in any free cycle without using the port.
  always_comb begin
    rf_we_c    = WRITE_DISABLE;
    rf_waddr_c = '0;
    rf_wdata_c = '0;
    fifo_pop   = 1'b0;
    grant      = 1'b0;
    if (wb_busy) begin
      rf_we_c    = WRITE_ENABLE;
      rf_waddr_c = bus.wb_waddr;
      rf_wdata_c = bus.wb_wdata;
    end else if (head_valid) begin
      fifo_pop = 1'b1;
      if (head_live) begin
        grant      = 1'b1;
        rf_we_c    = WRITE_ENABLE;
        rf_waddr_c = head_addr;
        rf_wdata_c = head_data;
      end
    end else if (lu_bypass) begin
      rf_we_c    = WRITE_ENABLE;
      rf_waddr_c = bus.lu_waddr;
      rf_wdata_c = bus.lu_wdata;
    end
  end

  // Any pop exposes a new head, so its wait restarts from zero.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (fifo_pop || !head_valid) begin
      wait_cnt_d = '0;
    end else if (head_live && (wait_cnt_q != WAIT_SAT)) begin
      wait_cnt_d = wait_cnt_q + WC_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fifo_push) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (fifo_pop && (cnt_after == '0)) begin
          state_d = ST_IDLE;
        end else if (head_live && !grant && (wait_cnt_q == WAIT_TRIP)) begin
          state_d = ST_STARVE;
        end
      end
      ST_STARVE: begin
        if (fifo_pop) state_d = (cnt_after == '0) ? ST_IDLE : ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Writeback inputs may be active while reset is held; keep the port quiet.
  assign bus.rf_we      = rf_we_c && !rst;
  assign bus.rf_waddr   = rst ? '0 : rf_waddr_c;
  assign bus.rf_wdata   = rst ? '0 : rf_wdata_c;
  assign bus.lu_ready   = lu_ready;
  assign bus.pend_hit1  = hit1;
  assign bus.pend_hit2  = hit2;
  assign bus.stall_req  = (state_q == ST_STARVE);
  assign bus.fifo_count = fifo_count;

endmodule
